serdes_tx_scheduler: RTL and testbench

Round-robin transmit scheduler for the 4-lane SerDes datapath. It shares the single 32-bit transmit word slot (one 8b/10b encoder plus PISO per byte lane) among NUM_REQ requesters. A new word is issued exactly once every FRAME_CYCLES clocks, and idle fill is inserted when no requester is ready. It sits between the packet sources and the SerDes `data_in` port, and produces the load strobe that paces the encoders.

---
 rtl/serdes_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/serdes_tx_scheduler.sv | 147 ++++++++++++++
 tb/tb_serdes_tx_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_sched_pkg.sv
// serdes_sched_pkg
//   Shared types and constants for the SerDes transmit scheduler.
//   state_t         : scheduler FSM states (S_ARB, S_LOAD, S_WAIT)
//   SCHED_TX_WORD_W : width of one transmit word (one byte per lane, 4 lanes)
//   SCHED_IDLE_WORD : default fill word sent when no requester is ready
//   rr_next()       : round-robin successor of an index, modulo n

package serdes_sched_pkg;

    localparam int SCHED_TX_WORD_W = 32;
    localparam logic [SCHED_TX_WORD_W-1:0] SCHED_IDLE_WORD = 32'hBCBC_BCBC;

    typedef enum logic [1:0] {
        S_ARB  = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Picks the first asserted request at or
//   after rr_ptr, searching upward and wrapping modulo NUM_REQ.
//   Ports:
//     req       in  NUM_REQ  request vector
//     rr_ptr    in  PTR_W    highest-priority index for this decision
//     enable    in  1        gates the grant vector (winner/any_valid unaffected)
//     grant     out NUM_REQ  one-hot grant, all-zero when disabled or no request
//     winner    out PTR_W    index of the selected request (0 when none)
//     any_valid out 1        at least one request is asserted

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               any_valid
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_valid && req[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
        if (enable && any_valid) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/serdes_tx_scheduler.sv
// serdes_tx_scheduler
//   Shares the single 32-bit SerDes transmit slot among NUM_REQ requesters.
//   One word (data or idle fill) is issued every FRAME_CYCLES clocks:
//   1 arbitrate + 1 load + (FRAME_CYCLES-2) shift cycles.
//   Ports:
//     clk        in   clock
//     rst        in   synchronous, active-high reset
//     link_en    in   0 parks the scheduler in S_ARB (no grants, no loads)
//     req_valid  in   per-requester word available
//     req_data   in   requester i on bits [32i+31:32i]
//     req_ready  out  one-hot grant, combinational, only in S_ARB
//     tx_data    out  word for the SerDes data_in, held between loads
//     tx_load    out  one-cycle strobe, tx_data is new
//     tx_idle    out  tx_data is idle fill
//     tx_src     out  requester index that supplied tx_data (0 for fill)
//     frame_cnt  out  words issued, wrapping
//     idle_cnt   out  idle words issued, wrapping
//
//   state  | meaning
//   S_ARB  | arbitrate; capture winner word (or fill) when link_en=1
//   S_LOAD | tx_load high for one cycle, encoders latch tx_data
//   S_WAIT | serializers shift; tx_data frozen

module serdes_tx_scheduler
    import serdes_sched_pkg::*;
#(
    parameter int                          NUM_REQ      = 4,
    parameter int                          FRAME_CYCLES = 12,
    parameter logic [SCHED_TX_WORD_W-1:0]  IDLE_WORD    = SCHED_IDLE_WORD
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                link_en,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*SCHED_TX_WORD_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [SCHED_TX_WORD_W-1:0]          tx_data,
    output logic                                tx_load,
    output logic                                tx_idle,
    output logic [2:0]                          tx_src,
    output logic [15:0]                         frame_cnt,
    output logic [15:0]                         idle_cnt
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int WAIT_W = $clog2(FRAME_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FRAME_CYCLES - 3);

    state_t                        state_q;
    logic [PTR_W-1:0]              rr_ptr_q;
    logic [PTR_W-1:0]              rr_ptr_d;
    logic [WAIT_W-1:0]             wait_cnt_q;
    logic [SCHED_TX_WORD_W-1:0]    tx_data_q;
    logic                          tx_load_q;
    logic                          tx_idle_q;
    logic [2:0]                    tx_src_q;
    logic [15:0]                   frame_cnt_q;
    logic [15:0]                   idle_cnt_q;

    logic                          arb_en;
    logic [PTR_W-1:0]              winner;
    logic                          any_valid;
    logic [SCHED_TX_WORD_W-1:0]    req_word [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*SCHED_TX_WORD_W +: SCHED_TX_WORD_W];
    end

    // Grants are only offered while arbitrating on an enabled link; the rst
    // term keeps req_ready low during the reset cycle itself.
    assign arb_en = (state_q == S_ARB) && link_en && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .enable    (arb_en),
        .grant     (req_ready),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign rr_ptr_d = PTR_W'(rr_next(int'(winner), NUM_REQ));

    // Counters advance on the same edge that raises tx_load, so they read
    // consistently with the word being loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ARB;
            rr_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            tx_data_q   <= '0;
            tx_load_q   <= 1'b0;
            tx_idle_q   <= 1'b0;
            tx_src_q    <= '0;
            frame_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_ARB: begin
                    if (link_en) begin
                        state_q     <= S_LOAD;
                        tx_load_q   <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        if (any_valid) begin
                            tx_data_q <= req_word[winner];
                            tx_idle_q <= 1'b0;
                            tx_src_q  <= 3'(winner);
                            rr_ptr_q  <= rr_ptr_d;
                        end else begin
                            tx_data_q  <= IDLE_WORD;
                            tx_idle_q  <= 1'b1;
                            tx_src_q   <= '0;
                            idle_cnt_q <= idle_cnt_q + 16'd1;
                        end
                    end
                end
                S_LOAD: begin
                    state_q    <= S_WAIT;
                    tx_load_q  <= 1'b0;
                    wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= S_ARB;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_ARB;
                    tx_load_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign tx_idle   = tx_idle_q;
    assign tx_src    = tx_src_q;
    assign frame_cnt = frame_cnt_q;
    assign idle_cnt  = idle_cnt_q;

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// tb_serdes_tx_scheduler
//   Self-checking bench: directed table of frames, hand-written corner
//   sequences, and randomized frames checked against a frame-level model.

module tb_serdes_tx_scheduler;

    localparam int NREQ = 4;
    localparam int FC   = 12;
    localparam logic [31:0] IDLE = 32'hBCBC_BCBC;

    logic         clk;
    logic         rst;
    logic         link_en;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [31:0]  tx_data;
    logic         tx_load;
    logic         tx_idle;
    logic [2:0]   tx_src;
    logic [15:0]  frame_cnt;
    logic [15:0]  idle_cnt;

    int total = 0;
    int bad   = 0;

    // frame-level reference model state
    int m_ptr;
    int m_fc;
    int m_ic;

    typedef struct {
        logic [3:0]   v;
        logic [127:0] d;
        logic [3:0]   e_rdy;
        logic [31:0]  e_dat;
        logic [2:0]   e_src;
        logic         e_idl;
        logic [15:0]  e_fc;
        logic [15:0]  e_ic;
    } vec_t;

    vec_t tbl [10];

    serdes_tx_scheduler #(
        .NUM_REQ      (NREQ),
        .FRAME_CYCLES (FC),
        .IDLE_WORD    (IDLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .link_en   (link_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_idle   (tx_idle),
        .tx_src    (tx_src),
        .frame_cnt (frame_cnt),
        .idle_cnt  (idle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First valid requester at or after ptr, modulo NREQ; -1 when none.
    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (((v >> idx) & 4'b0001) != 4'b0000) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        link_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        m_fc  = 0;
        m_ic  = 0;
    endtask

    // Entered at the negedge of an S_ARB cycle; returns at the next S_ARB
    // negedge exactly FC clocks later. wviol counts any load, grant or data
    // change seen during the shift cycles.
    task automatic do_frame(input logic [3:0] v, input logic [127:0] d,
                            output logic [3:0] rdy, output logic ld,
                            output logic [31:0] dat, output logic [2:0] src,
                            output logic idl, output logic [15:0] fc,
                            output logic [15:0] ic, output int wviol);
        wviol     = 0;
        link_en   = 1'b1;
        req_valid = v;
        req_data  = d;
        #1;
        rdy = req_ready;
        if (tx_load) wviol++;
        @(negedge clk);
        ld  = tx_load;
        dat = tx_data;
        src = tx_src;
        idl = tx_idle;
        fc  = frame_cnt;
        ic  = idle_cnt;
        req_valid = 4'($urandom);
        repeat (FC - 2) begin
            @(negedge clk);
            if (tx_load || req_ready != 4'b0000 || tx_data != dat) wviol++;
            req_valid = 4'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic rand_frame(input string tag);
        logic [3:0]   v, rdy;
        logic [127:0] d, sh;
        logic         ld, idl;
        logic [31:0]  dat, e_dat;
        logic [2:0]   src;
        logic [15:0]  fc, ic;
        int           wv, w;
        v = 4'($urandom);
        d = {$urandom, $urandom, $urandom, $urandom};
        w = pick(v, m_ptr);
        do_frame(v, d, rdy, ld, dat, src, idl, fc, ic, wv);
        m_fc = (m_fc + 1) & 16'hFFFF;
        if (w >= 0) begin
            sh    = d >> (32 * w);
            e_dat = sh[31:0];
            m_ptr = (w + 1) % NREQ;
        end else begin
            e_dat = IDLE;
            m_ic  = (m_ic + 1) & 16'hFFFF;
        end
        chk({tag, "_rdy"},  rdy, (w >= 0) ? (4'b0001 << w) : 4'b0000);
        chk({tag, "_load"}, ld,  1'b1);
        chk({tag, "_data"}, dat, e_dat);
        chk({tag, "_src"},  src, (w >= 0) ? 3'(w) : 3'd0);
        chk({tag, "_idle"}, idl, (w < 0));
        chk({tag, "_fcnt"}, fc,  16'(m_fc));
        chk({tag, "_icnt"}, ic,  16'(m_ic));
        chk({tag, "_wait"}, wv,  0);
    endtask

    initial begin
        logic [127:0] dstd, d1;
        logic [3:0]   rdy;
        logic         ld, idl;
        logic [31:0]  dat;
        logic [2:0]   src;
        logic [15:0]  fc, ic;
        int           wv, viol;

        dstd = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        d1   = {32'hA3A3_0003, 32'hA2A2_0002, 32'hDEAD_BEEF, 32'hA0A0_0000};

        tbl[0] = '{4'b0010, d1,   4'b0010, 32'hDEAD_BEEF, 3'd1, 1'b0, 16'd1,  16'd0};
        tbl[1] = '{4'b0000, dstd, 4'b0000, IDLE,          3'd0, 1'b1, 16'd2,  16'd1};
        tbl[2] = '{4'b1111, dstd, 4'b0100, 32'hA2A2_0002, 3'd2, 1'b0, 16'd3,  16'd1};
        tbl[3] = '{4'b1111, dstd, 4'b1000, 32'hA3A3_0003, 3'd3, 1'b0, 16'd4,  16'd1};
        tbl[4] = '{4'b1111, dstd, 4'b0001, 32'hA0A0_0000, 3'd0, 1'b0, 16'd5,  16'd1};
        tbl[5] = '{4'b1111, dstd, 4'b0010, 32'hA1A1_0001, 3'd1, 1'b0, 16'd6,  16'd1};
        tbl[6] = '{4'b1011, dstd, 4'b1000, 32'hA3A3_0003, 3'd3, 1'b0, 16'd7,  16'd1};
        tbl[7] = '{4'b0001, dstd, 4'b0001, 32'hA0A0_0000, 3'd0, 1'b0, 16'd8,  16'd1};
        tbl[8] = '{4'b0001, dstd, 4'b0001, 32'hA0A0_0000, 3'd0, 1'b0, 16'd9,  16'd1};
        tbl[9] = '{4'b1000, dstd, 4'b1000, 32'hA3A3_0003, 3'd3, 1'b0, 16'd10, 16'd1};

        // reset state, with link and requests active to prove req_ready is gated
        rst       = 1'b1;
        link_en   = 1'b1;
        req_valid = 4'hF;
        req_data  = dstd;
        @(negedge clk);
        chk("rst_tx_data", tx_data,   32'h0);
        chk("rst_tx_load", tx_load,   1'b0);
        chk("rst_tx_idle", tx_idle,   1'b0);
        chk("rst_tx_src",  tx_src,    3'd0);
        chk("rst_fcnt",    frame_cnt, 16'd0);
        chk("rst_icnt",    idle_cnt,  16'd0);
        chk("rst_ready",   req_ready, 4'b0000);

        // link held down after reset: completely quiet, then first load
        link_en = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        viol = 0;
        repeat (50) begin
            #1;
            if (req_ready != 4'b0000 || tx_load) viol++;
            @(negedge clk);
        end
        chk("park_quiet", viol, 0);
        link_en = 1'b1;
        #1;
        chk("linkup_ready", req_ready, 4'b0001);
        @(negedge clk);
        chk("linkup_load", {tx_load, tx_src, tx_data}, {1'b1, 3'd0, 32'hA0A0_0000});
        repeat (FC - 1) @(negedge clk);

        // link dropped mid-frame: frame finishes with data frozen, then parks
        req_valid = 4'b0001;
        req_data  = {dstd[127:32], 32'h1234_5678};
        #1;
        @(negedge clk);
        chk("lkdrop_load", {tx_load, tx_data}, {1'b1, 32'h1234_5678});
        repeat (3) @(negedge clk);
        link_en   = 1'b0;
        req_valid = 4'hF;
        viol      = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_load || req_ready != 4'b0000 || tx_data != 32'h1234_5678) viol++;
        end
        chk("lkdrop_quiet", viol, 0);
        link_en = 1'b1;
        #1;
        chk("lkdrop_resume_ready", req_ready, 4'b0010);
        @(negedge clk);
        chk("lkdrop_resume_load", {tx_load, tx_src}, {1'b1, 3'd1});
        repeat (FC - 1) @(negedge clk);

        // directed table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_frame(tbl[i].v, tbl[i].d, rdy, ld, dat, src, idl, fc, ic, wv);
            chk($sformatf("tbl%0d_rdy", i),  rdy, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_load", i), ld,  1'b1);
            chk($sformatf("tbl%0d_data", i), dat, tbl[i].e_dat);
            chk($sformatf("tbl%0d_src", i),  src, tbl[i].e_src);
            chk($sformatf("tbl%0d_idle", i), idl, tbl[i].e_idl);
            chk($sformatf("tbl%0d_fcnt", i), fc,  tbl[i].e_fc);
            chk($sformatf("tbl%0d_icnt", i), ic,  tbl[i].e_ic);
            chk($sformatf("tbl%0d_wait", i), wv,  0);
        end

        // reset during S_WAIT discards the frame and restarts from requester 0
        link_en   = 1'b1;
        req_valid = 4'hF;
        req_data  = dstd;
        #1;
        @(negedge clk);
        chk("midrst_pre_src", {tx_load, tx_src}, {1'b1, 3'd0});
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_zero", {tx_data, tx_load, tx_idle, tx_src, frame_cnt, idle_cnt, req_ready},
            {32'h0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 4'b0000});
        rst = 1'b0;
        #1;
        chk("midrst_ready", req_ready, 4'b0001);
        @(negedge clk);
        chk("midrst_load", {tx_load, tx_src, frame_cnt}, {1'b1, 3'd0, 16'd1});
        repeat (FC - 1) @(negedge clk);

        // randomized frames with occasional link parking
        do_reset();
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                int n;
                n         = int'($urandom_range(1, 15));
                link_en   = 1'b0;
                viol      = 0;
                for (int c = 0; c < n; c++) begin
                    req_valid = 4'($urandom);
                    #1;
                    if (req_ready != 4'b0000 || tx_load) viol++;
                    @(negedge clk);
                end
                chk($sformatf("rnd%0d_park", f), viol, 0);
            end
            rand_frame($sformatf("rnd%0d", f));
        end

        // frame counter wrap from a preloaded 0xFFFF
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        #1;
        chk("fcnt_preload", frame_cnt, 16'hFFFF);
        m_fc = 16'hFFFF;
        rand_frame("wrap");
        chk("fcnt_wrap", frame_cnt, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
